// File: rtl/mandelbrot_iter_ctrl.sv
// Iteration controller for one Mandelbrot pixel: holds c and z, steps an external
// one-step ALU until escape or the iteration limit, then offers the result.
module mandelbrot_iter_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ITER_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     in_cr,
    input  logic [WIDTH-1:0]     in_ci,
    input  logic [ITER_BITS-1:0] max_iter,
    output logic [WIDTH-1:0]     alu_cr,
    output logic [WIDTH-1:0]     alu_ci,
    output logic [WIDTH-1:0]     alu_zr,
    output logic [WIDTH-1:0]     alu_zi,
    input  logic [WIDTH-1:0]     alu_out_zr,
    input  logic [WIDTH-1:0]     alu_out_zi,
    input  logic                 alu_size,
    input  logic                 alu_overflow,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ITER_BITS-1:0] res_iter,
    output logic                 res_escaped
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     cr_q, cr_d, ci_q, ci_d, zr_q, zr_d, zi_q, zi_d;
    logic [ITER_BITS-1:0] cnt_q, cnt_d, max_q, max_d, res_iter_q, res_iter_d;
    logic                 res_esc_q, res_esc_d;
    logic [ITER_BITS-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cr_q       <= '0;
            ci_q       <= '0;
            zr_q       <= '0;
            zi_q       <= '0;
            cnt_q      <= '0;
            max_q      <= '0;
            res_iter_q <= '0;
            res_esc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cr_q       <= cr_d;
            ci_q       <= ci_d;
            zr_q       <= zr_d;
            zi_q       <= zi_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            res_iter_q <= res_iter_d;
            res_esc_q  <= res_esc_d;
        end
    end

    // cnt stays below max_q while iterating, so the increment cannot wrap
    assign cnt_inc = cnt_q + ITER_BITS'(1);

    always_comb begin
        state_d    = state_q;
        cr_d       = cr_q;
        ci_d       = ci_q;
        zr_d       = zr_q;
        zi_d       = zi_q;
        cnt_d      = cnt_q;
        max_d      = max_q;
        res_iter_d = res_iter_q;
        res_esc_d  = res_esc_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    cr_d  = in_cr;
                    ci_d  = in_ci;
                    max_d = max_iter;
                    zr_d  = '0;
                    zi_d  = '0;
                    cnt_d = '0;
                    if (max_iter == '0) begin
                        res_iter_d = '0;
                        res_esc_d  = 1'b0;
                        state_d    = DONE;
                    end else begin
                        state_d    = ITER;
                    end
                end
            end
            ITER: begin
                // escape wins over the limit when both hit in the same step
                if (alu_size || alu_overflow) begin
                    res_iter_d = cnt_q;
                    res_esc_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    zr_d  = alu_out_zr;
                    zi_d  = alu_out_zi;
                    cnt_d = cnt_inc;
                    if (cnt_inc == max_q) begin
                        res_iter_d = max_q;
                        res_esc_d  = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign res_iter    = res_iter_q;
    assign res_escaped = res_esc_q;
    assign alu_cr      = cr_q;
    assign alu_ci      = ci_q;
    assign alu_zr      = zr_q;
    assign alu_zi      = zi_q;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Bench for mandelbrot_iter_ctrl: attaches a fixed-point z^2+c ALU and compares
// each job against a plain-arithmetic escape-time model.
module tb_mandelbrot_iter_ctrl;
    localparam int W  = 8;
    localparam int IB = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid, start_ready;
    logic [W-1:0]  in_cr, in_ci;
    logic [IB-1:0] max_iter;
    logic [W-1:0]  alu_cr, alu_ci, alu_zr, alu_zi, alu_out_zr, alu_out_zi;
    logic          alu_size, alu_overflow, a_sz, a_ov;
    logic          res_valid, res_ready, res_escaped;
    logic [IB-1:0] res_iter;
    logic          force_ovf = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] tr_zr[$];
    logic [W-1:0] tr_zi[$];

    always #5 clk = ~clk;

    mandelbrot_iter_ctrl #(.WIDTH(W), .ITER_BITS(IB)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .in_cr(in_cr), .in_ci(in_ci), .max_iter(max_iter),
        .alu_cr(alu_cr), .alu_ci(alu_ci), .alu_zr(alu_zr), .alu_zi(alu_zi),
        .alu_out_zr(alu_out_zr), .alu_out_zi(alu_out_zi),
        .alu_size(alu_size), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_iter(res_iter), .res_escaped(res_escaped)
    );

    // z' = z^2 + c in 2.6 fixed point; size = |z|^2 > 4, overflow = z' not representable
    function automatic void alu_fn(input logic signed [7:0] cr, ci, zr, zi,
                                   output logic [7:0] ozr, ozi, output logic sz, ov);
        int r, i, nr, ni;
        r  = int'(zr);
        i  = int'(zi);
        nr = ((r*r - i*i) >>> 6) + int'(cr);
        ni = ((2*r*i) >>> 6) + int'(ci);
        ozr = 8'(nr);
        ozi = 8'(ni);
        sz  = (r*r + i*i) > 16384;
        ov  = (nr < -128) || (nr > 127) || (ni < -128) || (ni > 127);
    endfunction

    always_comb begin
        alu_fn(alu_cr, alu_ci, alu_zr, alu_zi, alu_out_zr, alu_out_zi, a_sz, a_ov);
        alu_size     = a_sz;
        alu_overflow = a_ov | force_ovf;
    end

    // Escape-time reference: trace[k] is z seen in the k-th cycle after accept
    function automatic void model(input logic [7:0] cr, ci, input int mx, fstep,
                                  output int it, esc, steps);
        logic [7:0] zr, zi, nzr, nzi;
        logic sz, ov;
        int cnt;
        zr = '0; zi = '0; cnt = 0; it = 0; esc = 0; steps = 0;
        tr_zr.delete(); tr_zi.delete();
        tr_zr.push_back(zr); tr_zi.push_back(zi);
        if (mx == 0) return;
        forever begin
            alu_fn(cr, ci, zr, zi, nzr, nzi, sz, ov);
            if (sz || ov || cnt == fstep) begin
                it = cnt; esc = 1; steps = cnt + 1;
                tr_zr.push_back(zr); tr_zi.push_back(zi);
                return;
            end
            zr = nzr; zi = nzi; cnt++;
            tr_zr.push_back(zr); tr_zi.push_back(zi);
            if (cnt == mx) begin
                it = mx; esc = 0; steps = mx;
                return;
            end
        end
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [7:0] cr, ci, input int mx, fstep, hold);
        int it, esc, steps, k;
        logic [IB-1:0] h_iter;
        logic          h_esc;
        logic [W-1:0]  h_zr;
        model(cr, ci, mx, fstep, it, esc, steps);
        @(negedge clk);
        start_valid = 1'b1; in_cr = cr; in_ci = ci; max_iter = IB'(mx); res_ready = 1'b0;
        chk("start_ready_idle", start_ready, 1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        in_cr = 8'($urandom); in_ci = 8'($urandom); max_iter = IB'($urandom);
        k = 0;
        while (!res_valid && k < 200) begin
            if (k < tr_zr.size()) begin
                chk("alu_zr_step", alu_zr, tr_zr[k]);
                chk("alu_zi_step", alu_zi, tr_zi[k]);
            end
            force_ovf = (k == fstep);
            @(posedge clk); #1;
            force_ovf = 1'b0;
            k++;
        end
        chk("latency", k, steps);
        chk("res_iter", res_iter, it);
        chk("res_escaped", res_escaped, esc);
        chk("alu_cr_done", alu_cr, cr);
        chk("alu_ci_done", alu_ci, ci);
        if (steps < tr_zr.size()) chk("alu_zr_done", alu_zr, tr_zr[steps]);
        chk("start_ready_done", start_ready, 0);
        h_iter = res_iter; h_esc = res_escaped; h_zr = alu_zr;
        repeat (hold) begin
            @(negedge clk);
            start_valid = 1'($urandom); in_cr = 8'($urandom); max_iter = IB'($urandom);
            @(posedge clk); #1;
            chk("bp_valid", res_valid, 1);
            chk("bp_start_ready", start_ready, 0);
            chk("bp_iter", res_iter, it);
            chk("bp_esc", res_escaped, esc);
            chk("bp_zr_stable", alu_zr, h_zr);
            chk("bp_cr_stable", alu_cr, cr);
        end
        @(negedge clk);
        start_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("handshake_valid", res_valid, 0);
        chk("handshake_idle", start_ready, 1);
    endtask

    initial begin
        int mx, fs;
        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
        in_cr = '0; in_ci = '0; max_iter = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_iter", res_iter, 0);
        chk("rst_res_escaped", res_escaped, 0);
        chk("rst_alu_cr", alu_cr, 0);
        chk("rst_alu_ci", alu_ci, 0);
        chk("rst_alu_zr", alu_zr, 0);
        chk("rst_alu_zi", alu_zi, 0);
        @(negedge clk); rst = 1'b0;

        run_job(8'h00, 8'h00, 10, -1, 0);   // limit reached, z stays 0
        run_job(8'h80, 8'h00, 63, -1, 0);   // c = -2.0 escapes by overflow
        run_job(8'h05, 8'h03, 0, -1, 0);    // zero limit
        run_job(8'h0a, 8'h14, 7, -1, 5);    // backpressure with start pulses
        run_job(8'h00, 8'h00, 5, 4, 0);     // escape and limit in the same step

        // reset in the 4th ITER cycle discards the job
        @(negedge clk);
        start_valid = 1'b1; in_cr = 8'hf0; in_ci = 8'h08; max_iter = IB'(20);
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_start_ready", start_ready, 1);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_iter", res_iter, 0);
        chk("midrst_alu_cr", alu_cr, 0);
        chk("midrst_alu_ci", alu_ci, 0);
        chk("midrst_alu_zr", alu_zr, 0);
        chk("midrst_alu_zi", alu_zi, 0);
        @(negedge clk); rst = 1'b0;
        run_job(8'hf0, 8'h08, 20, -1, 0);

        for (int j = 0; j < 25; j++) begin
            mx = int'($urandom_range(0, 63));
            fs = (($urandom % 4) == 0 && mx > 0) ? int'($urandom_range(0, mx - 1)) : -1;
            run_job(8'($urandom), 8'($urandom), mx, fs, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
